// File: rtl/img_preproc_pkg.sv
// Shared definitions for the image preprocessing pipeline.
//
// Used by both the clamped-at-zero subtractor and the saturating adder so
// that the notion of "largest pixel value" and clamping live in one place.
//
// Contents:
//   PIX_MAX_W  - widest pixel supported by the helpers (16 bits)
//   pix_max()  - 2^width - 1 for a given pixel width
//   sat_clip() - clamp an up-to-(PIX_MAX_W+1)-bit value to [0, pix_max(width)]
package img_preproc_pkg;

    localparam int unsigned PIX_MAX_W = 16;

    function automatic int unsigned pix_max(input int unsigned width);
        return (32'd1 << width) - 32'd1;
    endfunction

    // Returns the value clamped to the pixel range. The result is padded to
    // PIX_MAX_W bits; callers cast it down to their own pixel width.
    function automatic logic [PIX_MAX_W-1:0] sat_clip(input logic [PIX_MAX_W:0] val,
                                                      input int unsigned       width);
        int unsigned v;
        int unsigned m;
        v = 32'(val);
        m = pix_max(width);
        if (v > m) begin
            return 16'(m);
        end
        return 16'(v);
    endfunction

endpackage

// File: rtl/img_pipe_stage.sv
// Generic pipeline register: a data word plus its valid flag, with a hold
// enable for backpressure.
//
// Ports:
//   clk, rst_n  - clock, synchronous active-low reset
//   hold        - when 1 the stage keeps its current contents
//   in_valid    - valid flag of the word presented at in_data
//   in_data     - W-bit payload
//   out_valid   - registered valid flag
//   out_data    - registered payload
module img_pipe_stage #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         hold,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    output logic [W-1:0] out_data
);

    // Payload is captured together with the valid flag so that bubbles simply
    // overwrite stale data; nothing downstream looks at data while invalid.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (!hold) begin
            out_valid <= in_valid;
            out_data  <= in_data;
        end
    end

endmodule

// File: rtl/img_sat_adder.sv
// Streaming saturating pixel adder: m_sum = min(s_a + s_b, 2^WIDTH - 1).
//
// Reconstruction-path partner of the clamped-at-zero image subtractor.
// Two registered stages with full valid/ready backpressure; one pixel per
// cycle, two cycles from input acceptance to m_valid.
//
// Ports:
//   clk, rst_n           - clock, synchronous active-low reset
//   s_valid/s_ready      - input handshake
//   s_a, s_b             - WIDTH-bit unsigned operands
//   s_last               - last pixel of the frame
//   m_valid/m_ready      - output handshake
//   m_sum                - saturated sum
//   m_last               - s_last travelling with its pixel
//   m_sat                - 1 when this pixel was clamped
//   frame_sat_cnt        - clamped-pixel count of the last completed frame
//   frame_done           - one-cycle pulse when frame_sat_cnt updates
//
// Configuration:
//   IMG_SAT_ADDER_STATS_EN - when defined, builds the per-frame saturation
//   counter. When undefined, frame_sat_cnt and frame_done are tied to 0;
//   the datapath and m_sat are identical in both builds.
module img_sat_adder #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_a,
    input  logic [WIDTH-1:0] s_b,
    input  logic             s_last,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_sum,
    output logic             m_last,
    output logic             m_sat,
    output logic [CNT_W-1:0] frame_sat_cnt,
    output logic             frame_done
);

    import img_preproc_pkg::*;

    localparam int unsigned STAGE_W = WIDTH + 2;
    localparam int unsigned CLIP_W  = PIX_MAX_W + 1;

    logic               stall;
    logic [WIDTH:0]     sum_ext;
    logic [STAGE_W-1:0] s1_data;
    logic               s1_valid;
    logic [WIDTH:0]     s1_sum;
    logic               s1_last;
    logic               s1_sat;
    logic [WIDTH-1:0]   s1_clipped;
    logic [STAGE_W-1:0] s2_in;
    logic [STAGE_W-1:0] s2_data;

    // Both stages move together: a stall freezes the whole pipe, otherwise
    // everything shifts, which also squeezes out any bubbles.
    assign stall   = m_valid && !m_ready;
    assign s_ready = !stall;

    // One extra bit keeps the carry, which is exactly the overflow flag.
    assign sum_ext = {1'b0, s_a} + {1'b0, s_b};

    img_pipe_stage #(.W(STAGE_W)) u_stage1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .hold      (stall),
        .in_valid  (s_valid),
        .in_data   ({s_last, sum_ext}),
        .out_valid (s1_valid),
        .out_data  (s1_data)
    );

    assign s1_last    = s1_data[WIDTH+1];
    assign s1_sum     = s1_data[WIDTH:0];
    assign s1_sat     = s1_sum[WIDTH];
    assign s1_clipped = WIDTH'(sat_clip(CLIP_W'(s1_sum), WIDTH));
    assign s2_in      = {s1_last, s1_sat, s1_clipped};

    img_pipe_stage #(.W(STAGE_W)) u_stage2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .hold      (stall),
        .in_valid  (s1_valid),
        .in_data   (s2_in),
        .out_valid (m_valid),
        .out_data  (s2_data)
    );

    assign m_last = s2_data[WIDTH+1];
    assign m_sat  = s2_data[WIDTH];
    assign m_sum  = s2_data[WIDTH-1:0];

`ifdef IMG_SAT_ADDER_STATS_EN
    logic             out_fire;
    logic [CNT_W-1:0] run_cnt;
    logic [CNT_W-1:0] run_next;

    assign out_fire = m_valid && m_ready;

    // Running count including the pixel currently on the output, held at
    // full scale instead of wrapping.
    always_comb begin
        run_next = run_cnt;
        if (m_sat && (run_cnt != '1)) begin
            run_next = run_cnt + CNT_W'(1);
        end
    end

    // Only accepted output beats count; a last beat publishes the total and
    // restarts the count for the next frame.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            run_cnt       <= '0;
            frame_sat_cnt <= '0;
            frame_done    <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (out_fire) begin
                if (m_last) begin
                    frame_sat_cnt <= run_next;
                    run_cnt       <= '0;
                    frame_done    <= 1'b1;
                end else begin
                    run_cnt <= run_next;
                end
            end
        end
    end
`else
    assign frame_sat_cnt = '0;
    assign frame_done    = 1'b0;
`endif

endmodule

// File: tb/tb_img_sat_adder.sv
// Self-checking bench for img_sat_adder (WIDTH=8, CNT_W=24).
// Directed table vectors, a randomized backpressured stream, frame counter
// sequences and a mid-flight reset, all scored against a queue-based model.
module tb_img_sat_adder;

    localparam int unsigned W  = 8;
    localparam int unsigned CW = 24;

`ifdef IMG_SAT_ADDER_STATS_EN
    localparam bit STATS_ON = 1'b1;
`else
    localparam bit STATS_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [W-1:0]  s_a = '0;
    logic [W-1:0]  s_b = '0;
    logic          s_last = 1'b0;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [W-1:0]  m_sum;
    logic          m_last;
    logic          m_sat;
    logic [CW-1:0] frame_sat_cnt;
    logic          frame_done;

    int n_checks = 0;
    int n_fail   = 0;
    int done_seen = 0;
    bit rand_ready = 1'b0;

    typedef struct {
        int unsigned sum;
        bit          sat;
        bit          last;
    } exp_t;

    typedef struct {
        int unsigned a;
        int unsigned b;
        int unsigned exp_sum;
        bit          exp_sat;
    } vec_t;

    exp_t        exp_q[$];
    int unsigned run_cnt = 0;
    int unsigned exp_frame_cnt = 0;
    bit          done_pending = 1'b0;
    bit          prev_stall = 1'b0;

    always #5 clk = ~clk;

    img_sat_adder #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .s_valid       (s_valid),
        .s_ready       (s_ready),
        .s_a           (s_a),
        .s_b           (s_b),
        .s_last        (s_last),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .m_sum         (m_sum),
        .m_last        (m_last),
        .m_sat         (m_sat),
        .frame_sat_cnt (frame_sat_cnt),
        .frame_done    (frame_done)
    );

    task automatic checkOutput(input string name, input longint unsigned act,
                               input longint unsigned exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: plain integer sum, clamped to the pixel maximum.
    function automatic exp_t model(input int unsigned a, input int unsigned b, input bit last);
        exp_t        r;
        int unsigned s;
        int unsigned mx;
        s  = a + b;
        mx = (1 << W) - 1;
        r.sat  = (s > mx);
        r.sum  = r.sat ? mx : s;
        r.last = last;
        return r;
    endfunction

    function automatic longint unsigned stats_exp(input longint unsigned v);
        return STATS_ON ? v : 0;
    endfunction

    // Scoreboard, sampled on the falling edge while inputs are stable.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            run_cnt       = 0;
            exp_frame_cnt = 0;
            done_pending  = 1'b0;
            prev_stall    = 1'b0;
        end else begin
            checkOutput("frame_done", frame_done, stats_exp(done_pending));
            checkOutput("frame_sat_cnt", frame_sat_cnt, stats_exp(exp_frame_cnt));
            if (frame_done) done_seen++;
            done_pending = 1'b0;
            if (prev_stall) checkOutput("m_valid_hold", m_valid, 1);
            if (m_valid) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_beat", m_valid, 0);
                end else begin
                    checkOutput("sb_m_sum", m_sum, exp_q[0].sum);
                    checkOutput("sb_m_sat", m_sat, exp_q[0].sat);
                    checkOutput("sb_m_last", m_last, exp_q[0].last);
                end
            end
            if (s_valid && s_ready) exp_q.push_back(model(s_a, s_b, s_last));
            if (m_valid && m_ready && exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                if (e.sat) run_cnt++;
                if (e.last) begin
                    exp_frame_cnt = run_cnt;
                    run_cnt       = 0;
                    done_pending  = 1'b1;
                end
            end
            prev_stall = m_valid && !m_ready;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_ready) m_ready = 1'($urandom_range(0, 1));
    endtask

    // Presents one pixel pair and holds it until the block accepts it.
    task automatic applyStimulus(input int unsigned a, input int unsigned b, input bit last);
        bit acc;
        acc     = 1'b0;
        s_a     = W'(a);
        s_b     = W'(b);
        s_last  = last;
        s_valid = 1'b1;
        for (int i = 0; i < 200 && !acc; i++) begin
            @(negedge clk);
            acc = s_ready;
            tick();
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        if (!acc) checkOutput("accept_timeout", 0, 1);
    endtask

    task automatic drain();
        bit empty;
        empty      = 1'b0;
        rand_ready = 1'b0;
        m_ready    = 1'b1;
        for (int i = 0; i < 100 && !empty; i++) begin
            @(negedge clk);
            empty = (exp_q.size() == 0) && !m_valid;
            if (!empty) tick();
        end
        if (!empty) checkOutput("drain_timeout", 0, 1);
        tick();
        tick();
    endtask

    vec_t vecs[8];
    int   done_before;

    initial begin
        vecs[0] = '{a: 100, b: 50,  exp_sum: 150, exp_sat: 1'b0};
        vecs[1] = '{a: 200, b: 100, exp_sum: 255, exp_sat: 1'b1};
        vecs[2] = '{a: 128, b: 127, exp_sum: 255, exp_sat: 1'b0};
        vecs[3] = '{a: 0,   b: 0,   exp_sum: 0,   exp_sat: 1'b0};
        vecs[4] = '{a: 255, b: 255, exp_sum: 255, exp_sat: 1'b1};
        vecs[5] = '{a: 255, b: 0,   exp_sum: 255, exp_sat: 1'b0};
        vecs[6] = '{a: 1,   b: 255, exp_sum: 255, exp_sat: 1'b1};
        vecs[7] = '{a: 37,  b: 91,  exp_sum: 128, exp_sat: 1'b0};

        // Reset state
        rst_n = 1'b0;
        tick();
        tick();
        @(negedge clk);
        checkOutput("rst_m_valid", m_valid, 0);
        checkOutput("rst_s_ready", s_ready, 1);
        checkOutput("rst_m_sum", m_sum, 0);
        checkOutput("rst_m_last", m_last, 0);
        checkOutput("rst_m_sat", m_sat, 0);
        checkOutput("rst_frame_sat_cnt", frame_sat_cnt, 0);
        checkOutput("rst_frame_done", frame_done, 0);
        tick();
        rst_n   = 1'b1;
        m_ready = 1'b1;
        tick();

        // Directed vectors with latency check
        $display("[TB] directed vectors");
        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i].a, vecs[i].b, 1'b0);
            @(negedge clk);
            checkOutput("lat_m_valid_early", m_valid, 0);
            tick();
            @(negedge clk);
            checkOutput("lat_m_valid", m_valid, 1);
            checkOutput("vec_m_sum", m_sum, vecs[i].exp_sum);
            checkOutput("vec_m_sat", m_sat, vecs[i].exp_sat);
            tick();
        end
        drain();

        // Randomized stream under random backpressure
        $display("[TB] random stream");
        rand_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            applyStimulus($urandom_range(0, 255), $urandom_range(0, 255), i == 15);
            if ($urandom_range(0, 2) == 0) tick();
        end
        drain();

        // Frame of 10 pixels, 3 overflowing
        $display("[TB] frame counter");
        done_before = done_seen;
        for (int i = 0; i < 10; i++) begin
            if (i == 2 || i == 5 || i == 9) applyStimulus(200, 60 + i, i == 9);
            else                            applyStimulus(10 * i, 5, 1'b0);
        end
        drain();
        checkOutput("frame10_cnt", frame_sat_cnt, stats_exp(3));
        checkOutput("frame10_pulses", done_seen - done_before, stats_exp(1));

        // Next frame counts from zero
        done_before = done_seen;
        applyStimulus(250, 10, 1'b0);
        applyStimulus(20, 30, 1'b0);
        applyStimulus(40, 50, 1'b1);
        drain();
        checkOutput("frame3_cnt", frame_sat_cnt, stats_exp(1));
        checkOutput("frame3_pulses", done_seen - done_before, stats_exp(1));

        // Back-to-back single-pixel frames
        done_before = done_seen;
        applyStimulus(200, 100, 1'b1);
        applyStimulus(1, 2, 1'b1);
        drain();
        checkOutput("b2b_cnt", frame_sat_cnt, 0);
        checkOutput("b2b_pulses", done_seen - done_before, stats_exp(2));

        // Reset with two pixels in flight and the sink stalled
        $display("[TB] reset in flight");
        rand_ready = 1'b0;
        m_ready    = 1'b0;
        applyStimulus(250, 250, 1'b0);
        applyStimulus(3, 4, 1'b0);
        @(negedge clk);
        checkOutput("inflight_stall", s_ready, 0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("post_rst_m_valid", m_valid, 0);
        checkOutput("post_rst_s_ready", s_ready, 1);
        m_ready = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        @(negedge clk);
        checkOutput("post_rst_no_stale", m_valid, 0);
        applyStimulus(9, 8, 1'b1);
        drain();
        checkOutput("post_rst_frame_cnt", frame_sat_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/img_sat_adder.md
Name: img_sat_adder

Overview:
- Streaming saturating pixel adder: out = min(a + b, 2^WIDTH-1) per pixel, WIDTH-bit unsigned.
- Inverse-direction partner of the clamped-at-zero image subtractor: re-adds a background/offset plane to a difference image (reconstruction path).
- Sits in the image preprocessing pipeline between a valid/ready pixel source and sink.
- Two-stage registered pipeline with full backpressure and frame-end tracking.

Parameters:
- WIDTH, 8, pixel bit width (unsigned); legal range 2..16.
- CNT_W, 24, width of the per-frame saturation counter.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous reset, active-low
- s_valid  in  1  input pixel pair valid
- s_ready  out  1  block can accept input this cycle
- s_a  in  WIDTH  operand a
- s_b  in  WIDTH  operand b
- s_last  in  1  last pixel of frame
- m_valid  out  1  output pixel valid
- m_ready  in  1  downstream accepts output
- m_sum  out  WIDTH  saturated sum
- m_last  out  1  s_last delayed with its pixel
- m_sat  out  1  this output pixel was clamped
- frame_sat_cnt  out  CNT_W  clamped-pixel count of the last completed frame
- frame_done  out  1  one-cycle pulse when frame_sat_cnt updates

Behaviour:
- Reset (rst_n=0 at posedge clk): both stage-valid flags 0, m_valid=0, m_sum=0, m_last=0, m_sat=0, frame_sat_cnt=0, frame_done=0, running counter 0. Reset mid-frame discards all in-flight pixels; no output beat is produced for them.
- Handshake: transfer on s_valid&&s_ready (input) and m_valid&&m_ready (output). Once m_valid rises, m_sum/m_last/m_sat stay stable until accepted.
- Stall: stall = m_valid && !m_ready. s_ready = !stall (combinational from the stage-2 valid flag and m_ready). Both stages hold when stall=1; otherwise both advance every cycle (bubbles collapse).
- Stage 1: registers sum_ext = a + b at WIDTH+1 bits, plus last and valid.
- Stage 2: m_sat = sum_ext[WIDTH]; m_sum = all-ones if m_sat, else sum_ext[WIDTH-1:0].
- Latency: 2 cycles accept-to-m_valid without stall. Throughput: 1 pixel/cycle.
- Counter updates on each output transfer only.
  - Running count increments when m_sat=1, saturating at 2^CNT_W-1.
  - On a transfer with m_last=1: frame_sat_cnt <= running count + m_sat (saturated); running count <= 0; frame_done pulses on the following cycle for exactly 1 cycle.
- Boundaries:
  - a + b == 2^WIDTH-1 exactly: not saturated, m_sat=0.
  - 0 + 0 gives 0.
  - A single-pixel frame (s_last on the first beat) is legal.
  - Back-to-back last beats each produce a frame_done pulse.

Optional Feature:
- Macro IMG_SAT_ADDER_STATS_EN.
- Defined: the saturation counter, frame_sat_cnt and frame_done logic are built as described above.
- Undefined: the counter logic is removed, frame_sat_cnt is tied to 0 and frame_done to 0. m_sat is still produced. The datapath is unchanged.

Decomposition:
- Shared package img_preproc_pkg: pixel max constant function (2^WIDTH-1) and a saturate helper, both reused by the subtractor and the adder.
- One sub-module, img_pipe_stage: a generic data+valid register with hold enable, instantiated twice. The counter logic stays inline.

Test Plan:
- WIDTH=8, a=100, b=50, m_ready=1 -> m_sum=150 two cycles after accept, m_sat=0.
- a=200, b=100 -> m_sum=255, m_sat=1; a=128, b=127 -> m_sum=255, m_sat=0.
- Stream 16 random pairs with m_ready toggling randomly -> output order and values match the model; no loss or duplication; held outputs stable while m_ready=0.
- Frame of 10 pixels with 3 overflowing, s_last on the 10th -> frame_sat_cnt=3 and one frame_done pulse after the last transfer; the next frame starts counting from 0.
- Assert rst_n=0 with 2 pixels in flight and m_ready=0 -> m_valid=0 and s_ready=1 the cycle after reset; no stale beats afterwards.
- Build without IMG_SAT_ADDER_STATS_EN -> frame_sat_cnt stays 0 and frame_done never pulses; m_sum/m_sat match the stats-enabled build.
